mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Two-requester round-robin arbiter that sequences the shared 4-bit 2:1 output mux (`MUXB`). It owns the mux select, grants one requester at a time for a bounded burst of beats, and presents the selected data to a single downstream consumer over a valid/ready handshake. It sits between two 4-bit producers and the consumer, and drives the mux select that was previously a free testbench input.

## Interface
- `WIDTH`, 4: data width of each requester and of the output.
- `MAX_BURST`, 4: maximum beats per grant tenure; legal values are 1 to 15.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req0`, `req1`  in  1 each  request; held high while the requester has data.
- `d0`, `d1`  in  WIDTH each  requester data.
- `out_ready`  in  1  consumer accepts a beat this cycle.
- `gnt0`, `gnt1`  out  1 each  registered grant; one-hot or both zero.
- `sel`  out  1  mux select; 0 selects `d0`, 1 selects `d1`.
- `y`  out  WIDTH  selected data: `sel ? d1 : d0`, through the mux, combinational.
- `out_valid`  out  1  equals `(gnt0 & req0) | (gnt1 & req1)`.
- `beat_cnt`  out  4  beats transferred in the current tenure.

## Operation
- **States:** `IDLE`, `G0`, `G1`. The signals `gnt0`, `gnt1` and `sel` are decoded from registered state. In `IDLE`, `sel` holds its last value.
- **Transfer:** a beat transfers when `out_valid & out_ready` is high. For the granted requester, `gnt & out_ready` acts as its acknowledge.
- **Priority pointer `last`:** identifies the requester granted most recently. That requester has lower priority on the next tie.
- **From `IDLE`:**
  - If only one `req` is high, go to that requester's grant state.
  - If both are high, go to the requester that is not `last`.
  - If neither is high, stay in `IDLE`.
- **In `Gn`, release occurs when either:**
  - `req_n` is low at the clock edge, or
  - a transfer happens while `beat_cnt == MAX_BURST-1`.
- **On release:**
  - Set `last = n`.
  - If the other requester's `req` is high, go directly to the other grant state, with no idle bubble.
  - Otherwise, if `req_n` is still high (burst expired, no competitor), re-enter `Gn` with `beat_cnt` cleared.
  - Otherwise, go to `IDLE`.
- **`beat_cnt` rules:**
  - Clears to 0 on entry to any grant state and in `IDLE`.
  - Increments by 1 per transfer.
  - Never exceeds `MAX_BURST-1` at a clock edge.
- **Requester drops `req` mid-burst:** `out_valid` falls in the same cycle, because it is combinational on `req`. Release happens at the next edge.
- **No stall limit:** there is no timeout while `out_ready` is low. The grant is held indefinitely.

## Timing
- **Reset (synchronous, when `rst_n == 0` at an edge):**
  - State goes to `IDLE`.
  - `gnt0 = gnt1 = 0`, `sel = 0`, `beat_cnt = 0`, `last = 1`, so `req0` wins the first tie.
  - Consequently `out_valid = 0` and `y = d0`.
  - Reset asserted mid-burst aborts the tenure at that edge. No beat transfers in the cycle after the edge.
- **Arbitration latency:** `req` is sampled high in `IDLE` at edge k. Grant and `sel` are valid after edge k, and the first beat can transfer in the cycle following edge k.
- **Handover latency:** zero bubble cycles. The last beat of `G0` at edge k is followed by `gnt1` and `sel = 1` valid after edge k.
- **Maximum wait:** with both requesters continuously active and `out_ready` tied to 1, grants alternate every `MAX_BURST` cycles. The worst-case wait is `MAX_BURST` beats.
- **Glitch-free select:** `sel` changes only at clock edges, and only on a grant change.

## Test plan
- **Reset values:** drive `rst_n = 0` for 2 cycles with `req0 = req1 = 1`. Check `gnt0 = gnt1 = 0`, `sel = 0`, `out_valid = 0`, `beat_cnt = 0`. Release reset; check `gnt0 = 1` after the next edge (`last = 1` tie-break).
- **Single requester:** `d0 = 4'b0100`, `req0` held high, `out_ready = 1`, `MAX_BURST = 4`. Check `y = 4'b0100` every cycle and `beat_cnt` counting 0,1,2,3,0. `gnt0` stays high through the re-grant with no `IDLE` cycle.
- **Alternation:** `d0 = 4'b0100`, `d1 = 4'b0001`, both requesters active, `out_ready = 1`. Check `y` shows four beats of `0100`, then four of `0001`, repeating. `sel` toggles exactly at each fourth beat.
- **Stall:** in `G1`, hold `out_ready = 0` for 5 cycles while `req0 = 1`. Check `gnt1` holds and `beat_cnt` freezes. The handover to `G0` occurs only after the remaining beats complete.
- **Early drop:** in `G0` with `beat_cnt = 1`, drop `req0` while `req1 = 1`. Check `out_valid = 0` that cycle, `gnt1 = 1` and `sel = 1` after the next edge, and `beat_cnt = 0`.
- **Mid-burst reset:** assert `rst_n = 0` for 1 cycle during `G1` at `beat_cnt = 2`. Check all outputs return to reset values at that edge. Afterwards, `req0` wins if both requesters are active.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving the shared WIDTH-bit 2:1 output mux.
// Grants are bounded to MAX_BURST beats per tenure; handover has no idle bubble.

module muxb_lane (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [3:0]       beat_cnt
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic       sel_q, sel_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       xfer;

  assign gnt0      = (state == G0);
  assign gnt1      = (state == G1);
  assign sel       = sel_q;
  assign beat_cnt  = cnt;
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign xfer      = out_valid & out_ready;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    muxb_lane u_lane (
      .a (d0[i]),
      .b (d1[i]),
      .s (sel_q),
      .y (y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      sel_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      sel_q <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // on a tie the requester that was not granted last wins
        if (req0 && (!req1 || last)) state_nxt = G0;
        else if (req1)               state_nxt = G1;
      end
      G0: begin
        if (!req0 || (xfer && cnt == LAST_BEAT)) begin
          last_nxt = 1'b0;
          cnt_nxt  = '0;
          if (req1)      state_nxt = G1;
          else if (req0) state_nxt = G0;
          else           state_nxt = IDLE;
        end else if (xfer) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      G1: begin
        if (!req1 || (xfer && cnt == LAST_BEAT)) begin
          last_nxt = 1'b1;
          cnt_nxt  = '0;
          if (req0)      state_nxt = G0;
          else if (req1) state_nxt = G1;
          else           state_nxt = IDLE;
        end else if (xfer) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // select only moves with a grant; IDLE keeps the previous path
    if (state_nxt == G0)      sel_nxt = 1'b0;
    else if (state_nxt == G1) sel_nxt = 1'b1;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (WIDTH=4, MAX_BURST=4).
// Inputs change at the falling edge; outputs are checked at the falling edge.

module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] d0, d1;
  logic       out_ready;
  logic       gnt0, gnt1, sel, out_valid;
  logic [3:0] y, beat_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .d0        (d0),
    .d1        (d1),
    .out_ready (out_ready),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .y         (y),
    .out_valid (out_valid),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_all(input string tag, input int g0, input int g1, input int s,
                         input int v, input int c, input int yy);
    chk({tag, ".gnt0"},      int'(gnt0),      g0);
    chk({tag, ".gnt1"},      int'(gnt1),      g1);
    chk({tag, ".sel"},       int'(sel),       s);
    chk({tag, ".out_valid"}, int'(out_valid), v);
    chk({tag, ".beat_cnt"},  int'(beat_cnt),  c);
    chk({tag, ".y"},         int'(y),         yy);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    d0 = 4'b0100; d1 = 4'b0001; out_ready = 1'b1;

    // reset held for two edges with both requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 4);
    rst_n = 1'b1;

    // first tie goes to req0; then four beats each, alternating
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("alt%0d.sel", i),  int'(sel),      (i / 4) % 2);
      chk($sformatf("alt%0d.y", i),    int'(y),        ((i / 4) % 2) ? 1 : 4);
      chk($sformatf("alt%0d.cnt", i),  int'(beat_cnt), i % 4);
      chk($sformatf("alt%0d.gnt1", i), int'(gnt1),     (i / 4) % 2);
    end

    // stall in G1 at beat_cnt 1
    @(negedge clk);
    chk_all("stall_pre", 0, 1, 1, 1, 1, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all($sformatf("stall%0d", i), 0, 1, 1, 1, 1, 1);
    end
    out_ready = 1'b1;
    @(negedge clk); chk_all("drain2", 0, 1, 1, 1, 2, 1);
    @(negedge clk); chk_all("drain3", 0, 1, 1, 1, 3, 1);
    @(negedge clk); chk_all("handover_g0", 1, 0, 0, 1, 0, 4);

    // early drop of req0 at beat_cnt 1
    @(negedge clk); chk_all("drop_pre", 1, 0, 0, 1, 1, 4);
    req0 = 1'b0;
    #1 chk("drop.out_valid", int'(out_valid), 0);
    @(negedge clk); chk_all("drop_g1", 0, 1, 1, 1, 0, 1);
    req0 = 1'b1;

    // reset during G1 at beat_cnt 2
    @(negedge clk); chk("mrst.cnt1", int'(beat_cnt), 1);
    @(negedge clk); chk_all("mrst_pre", 0, 1, 1, 1, 2, 1);
    rst_n = 1'b0;
    @(negedge clk); chk_all("mrst", 0, 0, 0, 0, 0, 4);
    rst_n = 1'b1;
    @(negedge clk); chk_all("mrst_tie", 1, 0, 0, 1, 0, 4);

    // lone requester re-granted with no idle cycle
    req1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_all($sformatf("single%0d", i), 1, 0, 0, 1, i % 4, 4);
      @(negedge clk);
    end

    // no requests: IDLE keeps sel
    req0 = 1'b0;
    @(negedge clk); chk_all("idle0", 0, 0, 0, 0, 0, 4);
    req1 = 1'b1;
    @(negedge clk); chk_all("g1_alone", 0, 1, 1, 1, 0, 1);
    req1 = 1'b0;
    @(negedge clk); chk_all("idle1_hold", 0, 0, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
